sort4_seq_ctrl: RTL and testbench

Sequential 4-element sorter built around one shared compare-exchange unit. It schedules the 5-step network (0,2),(1,3),(0,1),(2,3),(1,2) over 5 clock cycles instead of instantiating 5 comparators. It has a valid/ready handshake on both input and output sides. It sits between a producer of 4-value bundles and a consumer, as a low-area replacement for the combinational 4-input sorter.

---
 rtl/sort4_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_sort4_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sort4_seq_ctrl.sv
// Sequential 4-element sorter: one shared compare-exchange unit runs the network (0,2),(1,3),(0,1),(2,3),(1,2).
// Latency: 5 cycles from accept edge to out_valid; one bundle per 7 cycles with out_ready held high.
// Backpressure: DONE holds the result until out_ready; in_ready is high only in IDLE.
// Optional: define SORT4_SWAP_CNT_EN to add the 3-bit swap_cnt output.
module sort4_seq_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_c,
  output logic [W-1:0] out_d,
`ifdef SORT4_SWAP_CNT_EN
  output logic [2:0]   swap_cnt,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   step_q, step_d;
  logic [W-1:0] r_q [4];
  logic [W-1:0] r_d [4];
  logic [1:0]   lo_idx, hi_idx;
  logic         do_swap;

  // Pair selection for the current network step; out-of-range steps behave as the last step
  always_comb begin
    lo_idx = 2'd1;
    hi_idx = 2'd2;
    case (step_q)
      3'd0: begin lo_idx = 2'd0; hi_idx = 2'd2; end
      3'd1: begin lo_idx = 2'd1; hi_idx = 2'd3; end
      3'd2: begin lo_idx = 2'd0; hi_idx = 2'd1; end
      3'd3: begin lo_idx = 2'd2; hi_idx = 2'd3; end
      default: begin lo_idx = 2'd1; hi_idx = 2'd2; end
    endcase
    // Strict compare: equal values stay in place
    do_swap = (state_q == SORT) && (r_q[lo_idx] > r_q[hi_idx]);
  end

  // Next-state, step and data-register update
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d[0]  = in_a;
          r_d[1]  = in_b;
          r_d[2]  = in_c;
          r_d[3]  = in_d;
          step_d  = 3'd0;
          state_d = SORT;
        end
      end
      SORT: begin
        if (do_swap) begin
          r_d[lo_idx] = r_q[hi_idx];
          r_d[hi_idx] = r_q[lo_idx];
        end
        if (step_q >= 3'd4) begin
          step_d  = 3'd0;
          state_d = DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 3'd0;
      end
    endcase
  end

  // State, step and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      r_q[0]  <= '0;
      r_q[1]  <= '0;
      r_q[2]  <= '0;
      r_q[3]  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      r_q[0]  <= r_d[0];
      r_q[1]  <= r_d[1];
      r_q[2]  <= r_d[2];
      r_q[3]  <= r_d[3];
    end
  end

`ifdef SORT4_SWAP_CNT_EN
  logic [2:0] swap_cnt_q, swap_cnt_d;

  // Swap counter: cleared on accept, bumped on each exchanging SORT edge, held otherwise
  always_comb begin
    swap_cnt_d = swap_cnt_q;
    if (state_q == IDLE && in_valid) begin
      swap_cnt_d = 3'd0;
    end else if (do_swap) begin
      swap_cnt_d = swap_cnt_q + 3'd1;
    end
  end

  // Swap counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cnt_q <= 3'd0;
    end else begin
      swap_cnt_q <= swap_cnt_d;
    end
  end

  assign swap_cnt = swap_cnt_q;
`endif

  // Handshake and status outputs decoded purely from registered state
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SORT);
  assign out_valid = (state_q == DONE);
  assign out_a     = r_q[0];
  assign out_b     = r_q[1];
  assign out_c     = r_q[2];
  assign out_d     = r_q[3];

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Directed bench for sort4_seq_ctrl: reset, sorting patterns, ties, back-pressure,
// input changes during sort and asynchronous reset in the middle of a sort.
module tb_sort4_seq_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b, in_c, in_d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         busy;
`ifdef SORT4_SWAP_CNT_EN
  logic [2:0]   swap_cnt;
`endif

  int n_tests;
  int n_fail;

  sort4_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
`ifdef SORT4_SWAP_CNT_EN
    .swap_cnt  (swap_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    check(tag, {out_a, out_b, out_c, out_d}, {a, b, c, d});
  endtask

  // Called at a negedge: presents a bundle, lets one rising edge accept it, returns at the next negedge
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
    in_a = a; in_b = b; in_c = c; in_d = d;
    in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
  endtask

  // Called at the negedge after the accept edge; checks out_valid rises exactly after the 5th edge.
  // When scramble is set, the inputs are changed every cycle of the sort.
  task automatic wait_done(input bit scramble);
    for (int i = 1; i <= 5; i++) begin
      if (scramble) begin
        in_a = W'($urandom_range(0, 15));
        in_b = W'($urandom_range(0, 15));
        in_c = W'($urandom_range(0, 15));
        in_d = W'($urandom_range(0, 15));
      end
      @(negedge clk);
      if (i < 5) check("no_early_valid", out_valid, 1'b0);
      else       check("valid_after_5", out_valid, 1'b1);
    end
    check("in_ready_low_in_done", in_ready, 1'b0);
    check("busy_low_in_done", busy, 1'b0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check_out("rst_outputs", 4'd0, 4'd0, 4'd0, 4'd0);
`ifdef SORT4_SWAP_CNT_EN
    check("rst_swap_cnt", swap_cnt, 3'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    // Basic sort {9,3,7,1}: every one of the five steps exchanges
    accept(4'd9, 4'd3, 4'd7, 4'd1);
    wait_done(1'b0);
    check_out("basic_sort", 4'd1, 4'd3, 4'd7, 4'd9);
`ifdef SORT4_SWAP_CNT_EN
    check("basic_swap_cnt", swap_cnt, 3'd5);
`endif
    @(negedge clk);
    check("basic_in_ready_next", in_ready, 1'b1);
    check("basic_valid_drop", out_valid, 1'b0);

    // Already sorted with a tie
    accept(4'd2, 4'd5, 4'd5, 4'd15);
    wait_done(1'b0);
    check_out("sorted_tie", 4'd2, 4'd5, 4'd5, 4'd15);
`ifdef SORT4_SWAP_CNT_EN
    check("sorted_swap_cnt", swap_cnt, 3'd0);
`endif
    @(negedge clk);

    // Duplicated extremes
    accept(4'd15, 4'd15, 4'd0, 4'd0);
    wait_done(1'b0);
    check_out("dup_extremes", 4'd0, 4'd0, 4'd15, 4'd15);
`ifdef SORT4_SWAP_CNT_EN
    check("dup_swap_cnt", swap_cnt, 3'd2);
`endif
    @(negedge clk);

    // Reverse order: last step finds the middle pair already ordered
    accept(4'd15, 4'd14, 4'd13, 4'd12);
    wait_done(1'b0);
    check_out("reverse", 4'd12, 4'd13, 4'd14, 4'd15);
`ifdef SORT4_SWAP_CNT_EN
    check("reverse_swap_cnt", swap_cnt, 3'd4);
`endif
    @(negedge clk);

    // Back-pressure: hold for 10 cycles while a competing bundle is offered
    out_ready = 1'b0;
    accept(4'd9, 4'd3, 4'd7, 4'd1);
    wait_done(1'b0);
    in_a = 4'd4; in_b = 4'd4; in_c = 4'd4; in_d = 4'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check_out("stall_hold", 4'd1, 4'd3, 4'd7, 4'd9);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_idle", in_ready, 1'b1);
    check_out("stall_not_captured", 4'd1, 4'd3, 4'd7, 4'd9);

    // Input changes during sort do not affect the result
    accept(4'd8, 4'd6, 4'd4, 4'd2);
    wait_done(1'b1);
    check_out("scramble_result", 4'd2, 4'd4, 4'd6, 4'd8);
    @(negedge clk);

    // Asynchronous reset at step 2
    accept(4'd8, 4'd6, 4'd4, 4'd2);
    @(negedge clk);
    @(negedge clk);
    check("midsort_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    check_out("arst_outputs", 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);
    end

    // Recovery after reset
    accept(4'd3, 4'd0, 4'd10, 4'd7);
    wait_done(1'b0);
    check_out("recovery", 4'd0, 4'd3, 4'd7, 4'd10);
    @(negedge clk);
    check("recovery_idle", in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so a stuck design still ends the run
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
